// File: rtl/matrix_access_arbiter.sv
// matrix_access_arbiter: single-port owner of the 80x50 game-matrix RAM.
// The display path reads while disp_active_i is high. During blanking, NUM_REQ
// game-logic requesters write through a round-robin req/ack handshake.
// Build macro ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins).
// Ports: clk, rst_n (sync, active low); disp_active_i/disp_x_i/disp_y_i display
// side; wr_req_i/wr_x_i/wr_y_i/wr_data_i packed requester inputs;
// wr_ack_o/wr_err_o one-cycle completion; mem_addr_o/mem_we_o/mem_wdata_o
// registered RAM port; disp_oob_o registered display out-of-range flag.
module matrix_access_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int CELL_W  = 2,
  parameter int MAT_W   = 80,
  parameter int MAT_H   = 50
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      disp_active_i,
  input  logic [6:0]                disp_x_i,
  input  logic [5:0]                disp_y_i,
  input  logic [NUM_REQ-1:0]        wr_req_i,
  input  logic [7*NUM_REQ-1:0]      wr_x_i,
  input  logic [6*NUM_REQ-1:0]      wr_y_i,
  input  logic [CELL_W*NUM_REQ-1:0] wr_data_i,
  output logic [NUM_REQ-1:0]        wr_ack_o,
  output logic [NUM_REQ-1:0]        wr_err_o,
  output logic [11:0]               mem_addr_o,
  output logic                      mem_we_o,
  output logic [CELL_W-1:0]         mem_wdata_o,
  output logic                      disp_oob_o
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, WR, ACK} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] win_q, win_d, pick;
  logic err_q, err_d, we_q, we_d, oob_q, oob_d;
  logic [11:0] addr_q, addr_d;
  logic [CELL_W-1:0] wdata_q, wdata_d, wd;
  logic [6:0] wx;
  logic [5:0] wy;
  logic grant;
  // y*80 + x as shifts; the row width is fixed at 80
  function automatic logic [11:0] addr_f(input logic [6:0] x, input logic [5:0] y);
    return {y, 6'b0} + {2'b0, y, 4'b0} + {5'b0, x};
  endfunction
  function automatic logic in_range(input logic [6:0] x, input logic [5:0] y);
    return (int'(x) < MAT_W) && (int'(y) < MAT_H);
  endfunction
  assign grant = (state_q == IDLE) && !disp_active_i && (|wr_req_i);
`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) if (wr_req_i[k]) pick = IW'(k);
  end
`else
  logic [IW-1:0] rr_q;
  logic [2*NUM_REQ-1:0] rot;
  int s;
  // rotate so bit 0 is the requester just after rr_q, then take the lowest set bit
  assign rot = {wr_req_i, wr_req_i} >> (int'(rr_q) + 1);
  always_comb begin
    pick = '0;
    s = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      s = int'(rr_q) + 1 + j;
      if (rot[j]) pick = IW'(s >= NUM_REQ ? s - NUM_REQ : s);
    end
  end
  always_ff @(posedge clk) rr_q <= !rst_n ? IW'(NUM_REQ - 1) : grant ? pick : rr_q;
`endif
  always_comb begin
    wx = '0;
    wy = '0;
    wd = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (pick == IW'(k)) begin
        wx = wr_x_i[7*k +: 7];
        wy = wr_y_i[6*k +: 6];
        wd = wr_data_i[CELL_W*k +: CELL_W];
      end
  end
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    oob_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (disp_active_i) begin
          addr_d = in_range(disp_x_i, disp_y_i) ? addr_f(disp_x_i, disp_y_i) : '0;
          oob_d  = !in_range(disp_x_i, disp_y_i);
        end else if (grant) begin
          win_d   = pick;
          err_d   = !in_range(wx, wy);
          we_d    = in_range(wx, wy);
          addr_d  = in_range(wx, wy) ? addr_f(wx, wy) : addr_q;
          wdata_d = in_range(wx, wy) ? wd : wdata_q;
          state_d = WR;
        end
      end
      WR:      state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      oob_q   <= oob_d;
    end
  end
  assign wr_ack_o    = (state_q == ACK) ? NUM_REQ'(1) << win_q : '0;
  assign wr_err_o    = (state_q == ACK && err_q) ? NUM_REQ'(1) << win_q : '0;
  assign mem_addr_o  = addr_q;
  assign mem_we_o    = we_q;
  assign mem_wdata_o = wdata_q;
  assign disp_oob_o  = oob_q;
endmodule

// File: tb/tb_matrix_access_arbiter.sv
// tb_matrix_access_arbiter: directed stimulus checked against a cycle model of the arbiter rules.
module tb_matrix_access_arbiter;
  localparam int N = 2;
  logic clk = 0, rst_n = 0, disp_active = 0;
  logic [6:0] disp_x = 0;
  logic [5:0] disp_y = 0;
  logic [N-1:0] wr_req = 0;
  logic [7*N-1:0] wr_x = 0;
  logic [6*N-1:0] wr_y = 0;
  logic [2*N-1:0] wr_data = 0;
  logic [N-1:0] wr_ack, wr_err;
  logic [11:0] mem_addr;
  logic mem_we, disp_oob;
  logic [1:0] mem_wdata;
  int checks = 0, errors = 0;
  int ea = 0, ewd = 0, eack = 0, eerr = 0, phase = 0, mrr = N - 1, mw = 0, cyc = 0;
  int mx, my;
  bit ewe = 0, eoob = 0, merr = 0, ok, started = 0;
  int log_idx[$], log_cyc[$];
  int exp_seq[4];

  matrix_access_arbiter dut (
    .clk(clk), .rst_n(rst_n), .disp_active_i(disp_active), .disp_x_i(disp_x), .disp_y_i(disp_y),
    .wr_req_i(wr_req), .wr_x_i(wr_x), .wr_y_i(wr_y), .wr_data_i(wr_data),
    .wr_ack_o(wr_ack), .wr_err_o(wr_err), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
    .mem_wdata_o(mem_wdata), .disp_oob_o(disp_oob)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", n, a, e, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic setreq(input int i, input int x, input int y, input int d);
    wr_x[7*i +: 7] = 7'(x);
    wr_y[6*i +: 6] = 6'(y);
    wr_data[2*i +: 2] = 2'(d);
  endtask

  // model: one write takes grant edge, a write cycle, an ack cycle; display reads only from idle
  initial forever begin
    @(posedge clk);
    started = 1;
    cyc++;
    if (!rst_n) begin
      ea = 0; ewd = 0; ewe = 0; eoob = 0; eack = 0; eerr = 0; mrr = N - 1; phase = 0;
    end else if (phase == 1) begin
      ewe = 0; eoob = 0; eack = 1 << mw; eerr = int'(merr) << mw; phase = 2;
    end else if (phase == 2) begin
      eack = 0; eerr = 0; phase = 0;
    end else if (disp_active) begin
      ok = disp_x < 80 && disp_y < 50;
      ea = ok ? int'(disp_y) * 80 + int'(disp_x) : 0;
      eoob = !ok;
      ewe = 0;
    end else if (wr_req != 0) begin
      mw = -1;
`ifdef ARB_FIXED_PRIO_EN
      for (int i = 0; i < N; i++) if (mw < 0 && wr_req[i]) mw = i;
`else
      for (int k = 1; k <= N; k++) if (mw < 0 && wr_req[(mrr + k) % N]) mw = (mrr + k) % N;
`endif
      mx = int'(wr_x[7*mw +: 7]);
      my = int'(wr_y[6*mw +: 6]);
      ok = mx < 80 && my < 50;
      merr = !ok;
      ewe = ok;
      if (ok) begin
        ea = my * 80 + mx;
        ewd = int'(wr_data[2*mw +: 2]);
      end
      mrr = mw;
      eoob = 0;
      phase = 1;
    end else begin
      ewe = 0; eoob = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("mem_addr", int'(mem_addr), ea);
      chk("mem_we", int'(mem_we), int'(ewe));
      chk("mem_wdata", int'(mem_wdata), ewd);
      chk("disp_oob", int'(disp_oob), int'(eoob));
      chk("wr_ack", int'(wr_ack), eack);
      chk("wr_err", int'(wr_err), eerr);
      for (int i = 0; i < N; i++) if (wr_ack[i]) begin
        log_idx.push_back(i);
        log_cyc.push_back(cyc);
      end
    end
  end

  initial begin
`ifdef ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    // reset with both requests already high
    wr_req = 2'b11;
    setreq(0, 1, 1, 1);
    setreq(1, 2, 0, 3);
    repeat (2) begin
      tick();
      @(negedge clk);
      chk("rst_ack", int'(wr_ack), 0);
      chk("rst_we", int'(mem_we), 0);
      chk("rst_addr", int'(mem_addr), 0);
    end
    rst_n = 1;
    tick();
    @(negedge clk);
    chk("first_we", int'(mem_we), 1);
    chk("first_addr", int'(mem_addr), 81);
    chk("first_wdata", int'(mem_wdata), 1);
    for (int c = 0; c < 30 && log_idx.size() < 4; c++) begin
      tick();
      @(negedge clk);
    end
    chk("ack_count", log_idx.size(), 4);
    if (log_idx.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        chk("grant_order", log_idx[i], exp_seq[i]);
        if (i > 0) chk("ack_spacing", log_cyc[i] - log_cyc[i-1], 3);
      end
    wr_req = 0;
    repeat (3) tick();
    // corner cell write
    setreq(0, 79, 49, 2);
    wr_req = 2'b01;
    tick();
    @(negedge clk);
    chk("corner_we", int'(mem_we), 1);
    chk("corner_addr", int'(mem_addr), 3999);
    chk("corner_wdata", int'(mem_wdata), 2);
    tick();
    @(negedge clk);
    chk("corner_ack", int'(wr_ack), 1);
    chk("corner_err", int'(wr_err), 0);
    wr_req = 0;
    repeat (2) tick();
    // out-of-range column
    setreq(1, 80, 0, 1);
    wr_req = 2'b10;
    tick();
    @(negedge clk);
    chk("oob_we", int'(mem_we), 0);
    tick();
    @(negedge clk);
    chk("oob_ack", int'(wr_ack), 2);
    chk("oob_err", int'(wr_err), 2);
    wr_req = 0;
    repeat (2) tick();
    // display owns the RAM while a request waits
    disp_active = 1;
    disp_x = 5;
    disp_y = 2;
    setreq(0, 3, 3, 1);
    wr_req = 2'b01;
    tick();
    @(negedge clk);
    chk("disp_addr", int'(mem_addr), 165);
    chk("disp_oob_lo", int'(disp_oob), 0);
    repeat (2) begin
      tick();
      @(negedge clk);
      chk("disp_no_ack", int'(wr_ack), 0);
      chk("disp_no_we", int'(mem_we), 0);
    end
    disp_x = 90;
    tick();
    @(negedge clk);
    chk("disp_oob_addr", int'(mem_addr), 0);
    chk("disp_oob_hi", int'(disp_oob), 1);
    disp_active = 0;
    tick();
    @(negedge clk);
    chk("post_disp_we", int'(mem_we), 1);
    chk("post_disp_addr", int'(mem_addr), 243);
    tick();
    @(negedge clk);
    chk("post_disp_ack", int'(wr_ack), 1);
    wr_req = 0;
    repeat (2) tick();
    // display rises while a write is in flight
    setreq(0, 10, 1, 3);
    wr_req = 2'b01;
    tick();
    disp_active = 1;
    disp_x = 7;
    disp_y = 0;
    @(negedge clk);
    chk("inflight_we", int'(mem_we), 1);
    chk("inflight_addr", int'(mem_addr), 90);
    tick();
    @(negedge clk);
    chk("inflight_ack", int'(wr_ack), 1);
    chk("inflight_we_off", int'(mem_we), 0);
    wr_req = 0;
    tick();
    @(negedge clk);
    chk("inflight_hold", int'(mem_addr), 90);
    tick();
    @(negedge clk);
    chk("inflight_disp", int'(mem_addr), 7);
    disp_active = 0;
    repeat (2) tick();
    // reset aborts a write in progress
    setreq(1, 0, 1, 1);
    wr_req = 2'b10;
    tick();
    rst_n = 0;
    @(negedge clk);
    chk("abort_we", int'(mem_we), 1);
    tick();
    @(negedge clk);
    chk("abort_we_off", int'(mem_we), 0);
    chk("abort_ack", int'(wr_ack), 0);
    rst_n = 1;
    wr_req = 0;
    tick();
    @(negedge clk);
    chk("abort_no_ack", int'(wr_ack), 0);
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
